// File: rtl/mdu_if.sv
// mdu_if: request/response bundle between the execute-stage control and the
// iterative multiply/divide unit.
//   master : drives start, op, a, b, hi_we, lo_we, wdata; observes results.
//   slave  : the unit itself; drives busy, done, hi, lo, dz.
// Signals:
//   start  request pulse, sampled only while the unit is idle
//   op     00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b   rs / rt operands
//   hi_we, lo_we, wdata  MTHI/MTLO write port
//   busy   operation in flight
//   done   one-cycle pulse when hi/lo are updated
//   hi, lo HI/LO registers
//   dz     divide-by-zero flag of the last completed operation
interface mdu_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             dz;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, hi, lo, dz
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, hi, lo, dz
    );
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: multi-cycle multiply/divide unit owning the HI/LO register pair.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes, with
// the result sign applied in a final FIX cycle.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset; aborts any operation, clears HI/LO
//   bus  mdu_if.slave (start/op/a/b/hi_we/lo_we/wdata in; busy/done/hi/lo/dz out)
// Timing: start accepted at edge k, iterations at k+1..k+ITER, results and a
// one-cycle done pulse at edge k+ITER+1. A new start is accepted while done is high.
// Optional build macro MDU_ZERO_SKIP_EN: a multiply with a zero operand or a
// divide by zero goes straight to FIX, so done follows one cycle after start.
module mdu_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ITER  = 32  // must equal WIDTH: one quotient/product bit per cycle
) (
    input logic  clk,
    input logic  rst,
    mdu_if.slave bus
);
    localparam int unsigned CW = $clog2(ITER + 1);
    localparam logic [WIDTH-1:0]   ONE  = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE2 = (2*WIDTH)'(1);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e             state;
    logic [CW-1:0]      cnt;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits / quotient bits}.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;      // multiplicand or divisor magnitude
    logic               is_div;
    logic               neg_q;     // negate product / quotient in FIX
    logic               neg_r;     // negate remainder in FIX
    logic               div_zero;
    logic               busy_r;
    logic               done_r;
    logic               dz_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
    assign bus.dz   = dz_r;

    // Latch-time operand decode
    logic             signed_op;
    logic             op_div;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             skip;

    always_comb begin
        signed_op = ~bus.op[0];
        op_div    = bus.op[1];
        mag_a     = (signed_op && bus.a[WIDTH-1]) ? (~bus.a + ONE) : bus.a;
        mag_b     = (signed_op && bus.b[WIDTH-1]) ? (~bus.b + ONE) : bus.b;
`ifdef MDU_ZERO_SKIP_EN
        skip      = op_div ? (bus.b == '0) : ((bus.a == '0) || (bus.b == '0));
`else
        skip      = 1'b0;
`endif
    end

    // One iteration of either datapath
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH+1:0]   diff;
    logic [2*WIDTH-1:0] acc_iter;
    logic               unused_diff_msb;

    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        // Extra guard bit so a zero divisor never reports a borrow; the
        // remainder then collects the whole dividend.
        diff      = {1'b0, rem_shift} - {2'b00, opnd};
        if (is_div) begin
            if (diff[WIDTH+1]) begin
                acc_iter = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end else begin
                acc_iter = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_iter = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    // Bit WIDTH of diff is only meaningful through the borrow bit above it.
    assign unused_diff_msb = diff[WIDTH];

    // Sign fix-up applied in FIX
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        prod_fix = neg_q ? (~acc + ONE2) : acc;
        // Divide by zero: all-ones quotient; the remainder already holds |A|
        // and the dividend-sign fix restores the original A.
        quo_fix  = div_zero ? '1 : (neg_q ? (~acc[WIDTH-1:0] + ONE) : acc[WIDTH-1:0]);
        rem_fix  = neg_r ? (~acc[2*WIDTH-1:WIDTH] + ONE) : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= StIdle;
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            dz_r     <= 1'b0;
            hi_r     <= '0;
            lo_r     <= '0;
        end else begin
            done_r <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (bus.start) begin
                        // start wins over a simultaneous MTHI/MTLO
                        busy_r   <= 1'b1;
                        is_div   <= op_div;
                        neg_q    <= signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        neg_r    <= signed_op & op_div & bus.a[WIDTH-1];
                        div_zero <= op_div & (bus.b == '0);
                        opnd     <= op_div ? mag_b : mag_a;
                        cnt      <= CW'(ITER);
                        if (skip) begin
                            // Preload the magnitude result the iterations would produce
                            acc   <= op_div ? {mag_a, {WIDTH{1'b1}}} : '0;
                            state <= StFix;
                        end else begin
                            acc   <= op_div ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
                            state <= StCalc;
                        end
                    end else begin
                        if (bus.hi_we) begin
                            hi_r <= bus.wdata;
                        end
                        if (bus.lo_we) begin
                            lo_r <= bus.wdata;
                        end
                    end
                end
                StCalc: begin
                    acc <= acc_iter;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= StFix;
                    end
                end
                StFix: begin
                    if (is_div) begin
                        hi_r <= rem_fix;
                        lo_r <= quo_fix;
                    end else begin
                        hi_r <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_r <= prod_fix[WIDTH-1:0];
                    end
                    dz_r   <= div_zero;
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                    cnt    <= '0;
                    state  <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: self-checking bench for mdu_iter. Expected results are pushed to
// a scoreboard queue when an operation is started and popped when done pulses.
`timescale 1ns/1ps
module tb_mdu_iter;
    localparam int W    = 32;
    localparam int LAT  = 33;
`ifdef MDU_ZERO_SKIP_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 33;
`endif
    localparam int TMO  = 80;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mdu_if #(.WIDTH(W)) bus ();

    mdu_iter #(.WIDTH(W), .ITER(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t scb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic exp_t mk(input logic [31:0] hi, input logic [31:0] lo,
                                input logic dz, input int lat);
        exp_t e;
        e.hi = hi; e.lo = lo; e.dz = dz; e.lat = lat;
        return e;
    endfunction

    // Reference model using 64-bit host arithmetic (truncating division)
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t        e;
        longint      sa, sbv, q, r;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        e.dz = 1'b0; e.lat = LAT;
        if (op[1] && b == 32'd0) begin
            e.hi = a; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1; e.lat = ZLAT;
        end else begin
            case (op)
                2'b00: p = 64'(sa * sbv);
                2'b01: p = {32'd0, a} * {32'd0, b};
                2'b10: begin
                    q = sa / sbv; r = sa % sbv;
                    p = {r[31:0], q[31:0]};
                end
                default: p = {({32'd0, a} % {32'd0, b}), ({32'd0, a} / {32'd0, b})} >> 0;
            endcase
            if (op == 2'b11) begin
                p[31:0]  = a / b;
                p[63:32] = a % b;
            end
            e.hi = p[63:32]; e.lo = p[31:0];
            if (!op[1] && (a == 32'd0 || b == 32'd0)) e.lat = ZLAT;
        end
        return e;
    endfunction

    task automatic drive_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input exp_t e);
        scb.push_back(e);
        drive_start(op, a, b);
    endtask

    // Returns cycles from the accepting edge to done, 0 on timeout
    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int c = 1; c <= TMO; c++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int ndone;
        @(posedge clk); #1;
        n_checks++;
        if ({bus.busy, bus.done, bus.dz, bus.hi, bus.lo} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b dz=%b hi=%h lo=%h expected all 0",
                     bus.busy, bus.done, bus.dz, bus.hi, bus.lo);
        end
        rst = 1'b0;
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hA5A5_5A5A;
        @(posedge clk); #1;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        drive_start(2'b00, 32'd5, 32'd9);
        repeat (9) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.busy, bus.done, bus.hi, bus.lo} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_calc: got busy=%b done=%b hi=%h lo=%h expected all 0",
                     bus.busy, bus.done, bus.hi, bus.lo);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            if (bus.done) ndone++;
        end
        n_checks++;
        if (ndone !== 0) begin
            n_fail++;
            $display("FAIL reset_no_done: got %0d done pulses expected 0", ndone);
        end
    endtask

    task automatic test_hilo_write();
        bus.hi_we = 1'b1; bus.wdata = 32'h1111_2222;
        @(posedge clk); #1;
        bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdata = 32'h3333_4444;
        @(posedge clk); #1;
        bus.lo_we = 1'b0;
        n_checks++;
        if ({bus.hi, bus.lo} !== 64'h1111_2222_3333_4444) begin
            n_fail++;
            $display("FAIL mthi_mtlo_single: got %h_%h expected 11112222_33334444", bus.hi, bus.lo);
        end
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h5555_6666;
        @(posedge clk); #1;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        n_checks++;
        if ({bus.hi, bus.lo} !== 64'h5555_6666_5555_6666) begin
            n_fail++;
            $display("FAIL mthi_mtlo_both: got %h_%h expected 55556666_55556666", bus.hi, bus.lo);
        end
    endtask

    task automatic test_mult();
        logic [1:0]  t_op [6];
        logic [31:0] t_a  [6];
        logic [31:0] t_b  [6];
        exp_t        t_e  [6];
        exp_t        e;
        int          c;
        t_op[0] = 2'b00; t_a[0] = 32'hFFFF_FFFD; t_b[0] = 32'd7;
        t_e[0]  = mk(32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, LAT);
        t_op[1] = 2'b01; t_a[1] = 32'hFFFF_FFFF; t_b[1] = 32'hFFFF_FFFF;
        t_e[1]  = mk(32'hFFFF_FFFE, 32'h0000_0001, 1'b0, LAT);
        t_op[2] = 2'b00; t_a[2] = 32'h8000_0000; t_b[2] = 32'h8000_0000;
        t_e[2]  = mk(32'h4000_0000, 32'h0000_0000, 1'b0, LAT);
        t_op[3] = 2'b00; t_a[3] = 32'd0; t_b[3] = 32'hFFFF_1234;
        t_e[3]  = mk(32'd0, 32'd0, 1'b0, ZLAT);
        for (int i = 4; i < 6; i++) begin
            t_op[i] = (i == 4) ? 2'b00 : 2'b01;
            t_a[i]  = $urandom;
            t_b[i]  = $urandom;
            t_e[i]  = model(t_op[i], t_a[i], t_b[i]);
        end
        for (int i = 0; i < 6; i++) begin
            issue(t_op[i], t_a[i], t_b[i], t_e[i]);
            wait_done(c);
            e = scb.pop_front();
            n_checks++;
            if (c !== e.lat) begin
                n_fail++;
                $display("FAIL mult[%0d]_latency: got %0d expected %0d", i, c, e.lat);
            end
            n_checks++;
            if ({bus.hi, bus.lo} !== {e.hi, e.lo}) begin
                n_fail++;
                $display("FAIL mult[%0d]_result: got %h_%h expected %h_%h",
                         i, bus.hi, bus.lo, e.hi, e.lo);
            end
            n_checks++;
            if (bus.dz !== e.dz) begin
                n_fail++;
                $display("FAIL mult[%0d]_dz: got %b expected %b", i, bus.dz, e.dz);
            end
        end
    endtask

    task automatic test_div();
        logic [1:0]  t_op [7];
        logic [31:0] t_a  [7];
        logic [31:0] t_b  [7];
        exp_t        t_e  [7];
        exp_t        e;
        int          c;
        t_op[0] = 2'b10; t_a[0] = 32'hFFFF_FFF9; t_b[0] = 32'd2;
        t_e[0]  = mk(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, LAT);
        t_op[1] = 2'b11; t_a[1] = 32'd100; t_b[1] = 32'd7;
        t_e[1]  = mk(32'd2, 32'd14, 1'b0, LAT);
        t_op[2] = 2'b10; t_a[2] = 32'h8000_0000; t_b[2] = 32'hFFFF_FFFF;
        t_e[2]  = mk(32'd0, 32'h8000_0000, 1'b0, LAT);
        t_op[3] = 2'b10; t_a[3] = 32'd7; t_b[3] = 32'hFFFF_FFFE;
        t_e[3]  = mk(32'd1, 32'hFFFF_FFFD, 1'b0, LAT);
        for (int i = 4; i < 7; i++) begin
            t_op[i] = (i == 5) ? 2'b11 : 2'b10;
            t_a[i]  = $urandom;
            t_b[i]  = $urandom >> $urandom_range(0, 30);
            if (t_b[i] == 32'd0) t_b[i] = 32'd3;
            t_e[i]  = model(t_op[i], t_a[i], t_b[i]);
        end
        for (int i = 0; i < 7; i++) begin
            issue(t_op[i], t_a[i], t_b[i], t_e[i]);
            wait_done(c);
            e = scb.pop_front();
            n_checks++;
            if (c !== e.lat) begin
                n_fail++;
                $display("FAIL div[%0d]_latency: got %0d expected %0d", i, c, e.lat);
            end
            n_checks++;
            if ({bus.hi, bus.lo} !== {e.hi, e.lo}) begin
                n_fail++;
                $display("FAIL div[%0d]_result: got hi=%h lo=%h expected hi=%h lo=%h",
                         i, bus.hi, bus.lo, e.hi, e.lo);
            end
        end
    endtask

    task automatic test_div_zero();
        logic [1:0]  t_op [4];
        logic [31:0] t_a  [4];
        logic [31:0] t_b  [4];
        exp_t        t_e  [4];
        exp_t        e;
        int          c;
        t_op[0] = 2'b11; t_a[0] = 32'd5; t_b[0] = 32'd0;
        t_e[0]  = mk(32'd5, 32'hFFFF_FFFF, 1'b1, ZLAT);
        t_op[1] = 2'b01; t_a[1] = 32'd2; t_b[1] = 32'd3;
        t_e[1]  = mk(32'd0, 32'd6, 1'b0, LAT);
        t_op[2] = 2'b10; t_a[2] = 32'hFFFF_FFF8; t_b[2] = 32'd0;
        t_e[2]  = mk(32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1, ZLAT);
        t_op[3] = 2'b11; t_a[3] = 32'd9; t_b[3] = 32'd3;
        t_e[3]  = mk(32'd0, 32'd3, 1'b0, LAT);
        for (int i = 0; i < 4; i++) begin
            issue(t_op[i], t_a[i], t_b[i], t_e[i]);
            wait_done(c);
            e = scb.pop_front();
            n_checks++;
            if (c !== e.lat) begin
                n_fail++;
                $display("FAIL dz[%0d]_latency: got %0d expected %0d", i, c, e.lat);
            end
            n_checks++;
            if ({bus.dz, bus.hi, bus.lo} !== {e.dz, e.hi, e.lo}) begin
                n_fail++;
                $display("FAIL dz[%0d]_result: got dz=%b hi=%h lo=%h expected dz=%b hi=%h lo=%h",
                         i, bus.dz, bus.hi, bus.lo, e.dz, e.hi, e.lo);
            end
        end
    endtask

    task automatic test_hazards();
        exp_t e;
        int   ndone, first, c;
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h0BAD_F00D;
        @(posedge clk); #1;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        issue(2'b01, 32'd3, 32'd5, mk(32'd0, 32'd15, 1'b0, LAT));
        ndone = 0; first = 0;
        for (int k = 1; k <= 70; k++) begin
            bus.start = (k == 5);
            bus.op = 2'b01; bus.a = 32'd7; bus.b = 32'd7;
            bus.hi_we = (k == 8);
            bus.wdata = 32'hDEAD_BEEF;
            @(posedge clk); #1;
            if (bus.done) begin
                ndone++;
                if (first == 0) first = k;
            end
            if (k == 20) begin
                n_checks++;
                if ({bus.busy, bus.hi, bus.lo} !== {1'b1, 32'h0BAD_F00D, 32'h0BAD_F00D}) begin
                    n_fail++;
                    $display("FAIL hold_during_calc: got busy=%b hi=%h lo=%h expected 1 0badf00d 0badf00d",
                             bus.busy, bus.hi, bus.lo);
                end
            end
        end
        bus.start = 1'b0; bus.hi_we = 1'b0;
        e = scb.pop_front();
        n_checks++;
        if (ndone !== 1 || first !== e.lat) begin
            n_fail++;
            $display("FAIL start_while_busy: got %0d dones first at %0d expected 1 at %0d",
                     ndone, first, e.lat);
        end
        n_checks++;
        if ({bus.hi, bus.lo} !== {e.hi, e.lo}) begin
            n_fail++;
            $display("FAIL hi_we_while_busy: got hi=%h lo=%h expected hi=%h lo=%h",
                     bus.hi, bus.lo, e.hi, e.lo);
        end
        // start and lo_we together in idle: the write is dropped
        bus.lo_we = 1'b1; bus.wdata = 32'h0000_1234;
        issue(2'b01, 32'd6, 32'd7, mk(32'd0, 32'd42, 1'b0, LAT));
        bus.lo_we = 1'b0;
        n_checks++;
        if (bus.lo !== 32'd15 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL start_beats_lo_we: got lo=%h busy=%b expected lo=0000000f busy=1",
                     bus.lo, bus.busy);
        end
        wait_done(c);
        e = scb.pop_front();
        n_checks++;
        if (c !== e.lat || bus.lo !== e.lo || bus.hi !== e.hi) begin
            n_fail++;
            $display("FAIL start_with_lo_we_result: got lat=%0d hi=%h lo=%h expected lat=%0d hi=%h lo=%h",
                     c, bus.hi, bus.lo, e.lat, e.hi, e.lo);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  t_op [3];
        logic [31:0] t_a  [3];
        logic [31:0] t_b  [3];
        exp_t        e;
        int          c;
        t_op[0] = 2'b01; t_a[0] = 32'd9;         t_b[0] = 32'd9;
        t_op[1] = 2'b11; t_a[1] = 32'd1000;      t_b[1] = 32'd10;
        t_op[2] = 2'b10; t_a[2] = 32'hFFFF_FF9C; t_b[2] = 32'd7;
        for (int i = 0; i < 3; i++) begin
            // For i > 0 this is driven in the cycle where the previous done is high
            issue(t_op[i], t_a[i], t_b[i], model(t_op[i], t_a[i], t_b[i]));
            n_checks++;
            if (bus.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b[%0d]_accepted: got busy=%b expected 1", i, bus.busy);
            end
            wait_done(c);
            e = scb.pop_front();
            n_checks++;
            if (c !== LAT || {bus.hi, bus.lo} !== {e.hi, e.lo}) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got lat=%0d hi=%h lo=%h expected lat=%0d hi=%h lo=%h",
                         i, c, bus.hi, bus.lo, LAT, e.hi, e.lo);
            end
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
        test_reset();
        test_hilo_write();
        test_mult();
        test_div();
        test_div_zero();
        test_hazards();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
